conv_frame_sequencer: RTL and testbench

Parametrised successor controller for the 2D convolution datapath: sequences image-column loading into N_BANKS line memories, the convolution pass, and result read-out. Generates read/write addresses, one-hot bank write select, convolver valid, and end-of-process flags. Sits between the host/GPIO command interface and the line-memory/convolver array, with configurable kernel size and pipeline latency.

---
 rtl/conv_frame_sequencer.sv | 168 ++++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_sequencer.sv
// Load / process / read-out sequencer for the line-memory convolution datapath.
// Optional macro CONV_FSM_STALL_EN: PROC advances only on cycles with i_valid=1.
module conv_frame_sequencer #(
    parameter int NB_ADDRESS   = 10,
    parameter int NB_IMAGE     = 10,
    parameter int N_BANKS      = 4,
    parameter int KERNEL_SIZE  = 3,
    parameter int CONV_LATENCY = 6
) (
    input  logic                  i_CLK,
    input  logic                  i_reset,
    input  logic [NB_IMAGE-1:0]   i_imgLength,
    input  logic                  i_load,
    input  logic                  i_SoP,
    input  logic                  i_valid,
    output logic [NB_ADDRESS-1:0] o_readAdd,
    output logic [NB_ADDRESS-1:0] o_writeAdd,
    output logic [N_BANKS-1:0]    o_bankSel,
    output logic                  o_valid_toCONV,
    output logic                  o_SOP_fromFSM,
    output logic                  o_EoP,
    output logic                  o_changeBlock,
    output logic                  o_protoErr
);

    typedef enum logic [2:0] {IDLE, LOAD, PROC, DONE, READ} state_t;

    state_t                state_reg;
    logic [NB_IMAGE-1:0]   img_height_reg;
    logic [NB_ADDRESS-1:0] read_add_reg;
    logic [NB_ADDRESS-1:0] lat_cnt_reg;
    logic [NB_ADDRESS-1:0] write_add_reg;
    logic [N_BANKS-1:0]    bank_sel_reg;
    logic                  valid_prev_reg;
    logic                  sop_reg;
    logic                  valid_conv_reg;
    logic                  eop_reg;
    logic                  change_block_reg;
    logic                  proto_err_reg;

    logic                  valid_rise;
    logic                  proc_step;
    logic [NB_IMAGE-1:0]   limit_img;
    logic [NB_ADDRESS-1:0] limit_add;
    logic [NB_ADDRESS-1:0] height_add;
    logic [NB_ADDRESS-1:0] read_add_inc;
    logic [NB_ADDRESS-1:0] lat_cnt_inc;
    logic                  cnt_at_end;
    logic                  lat_at_end;
    logic                  lat_go;

`ifdef CONV_FSM_STALL_EN
    assign proc_step = i_valid;
`else
    assign proc_step = 1'b1;
`endif

    // Write limit is formed at image width before being mapped onto the address space.
    assign limit_img    = img_height_reg - NB_IMAGE'(KERNEL_SIZE - 1);
    assign limit_add    = NB_ADDRESS'(limit_img);
    assign height_add   = NB_ADDRESS'(img_height_reg);
    assign valid_rise   = i_valid & ~valid_prev_reg;
    assign read_add_inc = read_add_reg + NB_ADDRESS'(1);
    assign lat_cnt_inc  = lat_cnt_reg + NB_ADDRESS'(1);
    assign cnt_at_end   = (read_add_reg == height_add);
    assign lat_at_end   = (lat_cnt_reg == limit_add);
    assign lat_go       = proc_step && (read_add_reg >= NB_ADDRESS'(CONV_LATENCY))
                          && (lat_cnt_reg < limit_add);

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state_reg        <= IDLE;
            img_height_reg   <= '0;
            read_add_reg     <= '0;
            lat_cnt_reg      <= '0;
            write_add_reg    <= '0;
            bank_sel_reg     <= {{(N_BANKS-1){1'b0}}, 1'b1};
            valid_prev_reg   <= 1'b0;
            sop_reg          <= 1'b0;
            valid_conv_reg   <= 1'b0;
            eop_reg          <= 1'b0;
            change_block_reg <= 1'b0;
            proto_err_reg    <= 1'b0;
        end else begin
            valid_prev_reg   <= i_valid;
            change_block_reg <= 1'b0;
            proto_err_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    read_add_reg   <= '0;
                    lat_cnt_reg    <= '0;
                    write_add_reg  <= '0;
                    img_height_reg <= i_imgLength;
                    if (i_load && i_SoP) begin
                        proto_err_reg <= 1'b1;
                    end else if (i_load && !eop_reg) begin
                        state_reg <= LOAD;
                    end else if (!i_load && i_SoP && !eop_reg) begin
                        // Too short for one kernel window: flag and report an empty result.
                        if (i_imgLength < NB_IMAGE'(KERNEL_SIZE)) begin
                            proto_err_reg <= 1'b1;
                            eop_reg       <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            sop_reg        <= 1'b1;
                            valid_conv_reg <= proc_step;
                            state_reg      <= PROC;
                        end
                    end else if (!i_load && !i_SoP && eop_reg) begin
                        state_reg <= READ;
                    end
                end
                LOAD, READ: begin
                    if (valid_rise && !cnt_at_end) begin
                        read_add_reg  <= read_add_inc;
                        write_add_reg <= read_add_inc;
                    end
                    if (cnt_at_end && !i_load) begin
                        change_block_reg <= 1'b1;
                        read_add_reg     <= '0;
                        write_add_reg    <= '0;
                        state_reg        <= IDLE;
                        if (state_reg == LOAD)
                            bank_sel_reg <= {bank_sel_reg[N_BANKS-2:0], bank_sel_reg[N_BANKS-1]};
                        else
                            eop_reg <= 1'b0;
                    end
                end
                PROC: begin
                    if (lat_at_end) begin
                        eop_reg        <= 1'b1;
                        sop_reg        <= 1'b0;
                        valid_conv_reg <= 1'b0;
                        write_add_reg  <= read_add_reg;
                        state_reg      <= DONE;
                    end else begin
                        valid_conv_reg <= proc_step;
                        if (proc_step && !cnt_at_end)
                            read_add_reg <= read_add_inc;
                        if (lat_go) begin
                            lat_cnt_reg   <= lat_cnt_inc;
                            write_add_reg <= lat_cnt_inc;
                        end
                    end
                end
                DONE: begin
                    if (!i_SoP) begin
                        read_add_reg  <= '0;
                        lat_cnt_reg   <= '0;
                        write_add_reg <= '0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_readAdd      = read_add_reg;
    assign o_writeAdd     = write_add_reg;
    assign o_bankSel      = bank_sel_reg;
    assign o_valid_toCONV = valid_conv_reg;
    assign o_SOP_fromFSM  = sop_reg;
    assign o_EoP          = eop_reg;
    assign o_changeBlock  = change_block_reg;
    assign o_protoErr     = proto_err_reg;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed/randomized bench for conv_frame_sequencer with an arithmetic address model.
// Define CONV_FSM_STALL_EN to also exercise the stalled PROC mode.
module tb_conv_frame_sequencer;

    localparam int LAT = 6;
    localparam int KS  = 3;

    logic       i_CLK;
    logic       i_reset;
    logic [9:0] i_imgLength;
    logic       i_load;
    logic       i_SoP;
    logic       i_valid;
    logic [9:0] o_readAdd;
    logic [9:0] o_writeAdd;
    logic [3:0] o_bankSel;
    logic       o_valid_toCONV;
    logic       o_SOP_fromFSM;
    logic       o_EoP;
    logic       o_changeBlock;
    logic       o_protoErr;

    int compared   = 0;
    int mismatched = 0;

    conv_frame_sequencer dut (
        .i_CLK          (i_CLK),
        .i_reset        (i_reset),
        .i_imgLength    (i_imgLength),
        .i_load         (i_load),
        .i_SoP          (i_SoP),
        .i_valid        (i_valid),
        .o_readAdd      (o_readAdd),
        .o_writeAdd     (o_writeAdd),
        .o_bankSel      (o_bankSel),
        .o_valid_toCONV (o_valid_toCONV),
        .o_SOP_fromFSM  (o_SOP_fromFSM),
        .o_EoP          (o_EoP),
        .o_changeBlock  (o_changeBlock),
        .o_protoErr     (o_protoErr)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    task automatic step();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rd"},   32'(o_readAdd), 0);
        chk({tag, "_wr"},   32'(o_writeAdd), 0);
        chk({tag, "_bank"}, 32'(o_bankSel), 1);
        chk({tag, "_flags"},
            32'({o_valid_toCONV, o_SOP_fromFSM, o_EoP, o_changeBlock, o_protoErr}), 0);
    endtask

    initial begin
        int h;
        int hi;
        int lo;
        int k_end;
        int exp_rd;
        int exp_wr;

        i_reset = 1'b1; i_imgLength = '0; i_load = 1'b0; i_SoP = 1'b0; i_valid = 1'b0;
        step(); step();
        chk_reset_values("reset");
        i_reset = 1'b0;
        step();

        // Five loads: the fifth shows the bank select wrapping around.
        for (int l = 0; l < 5; l++) begin
            h = (l == 0) ? 9 : int'($urandom_range(3, 30));
            i_imgLength = 10'(h);
            i_load = 1'b1;
            step();
            chk("load_start", 32'(o_writeAdd), 0);
            for (int e = 1; e <= h + 1; e++) begin
                hi = int'($urandom_range(1, 3));
                lo = int'($urandom_range(1, 2));
                exp_rd = (e > h) ? h : e;
                i_valid = 1'b1;
                for (int c = 0; c < hi; c++) begin
                    step();
                    chk("load_wr", 32'(o_writeAdd), 32'(exp_rd));
                    chk("load_rd", 32'(o_readAdd), 32'(exp_rd));
                end
                i_valid = 1'b0;
                for (int c = 0; c < lo; c++) step();
            end
            chk("load_no_cb", 32'(o_changeBlock), 0);
            i_load = 1'b0;
            step();
            chk("load_cb", 32'(o_changeBlock), 1);
            chk("load_bank", 32'(o_bankSel), 32'(1 << ((l + 1) % 4)));
            step();
            chk("load_cb_pulse", 32'(o_changeBlock), 0);
            chk("load_idle_rd", 32'(o_readAdd), 0);
        end

        // Process pass over a 20-row image.
        h = 20;
        k_end = (h - (KS - 1)) + LAT + 1;
        i_imgLength = 10'(h);
        i_valid = 1'b1;
        i_SoP = 1'b1;
        step();
        for (int k = 0; k < k_end; k++) begin
            if (k > 0) step();
            exp_rd = (k > h) ? h : k;
            exp_wr = (k <= LAT) ? 0 : (((k - LAT) > h - (KS - 1)) ? h - (KS - 1) : k - LAT);
            chk("proc_rd", 32'(o_readAdd), 32'(exp_rd));
            chk("proc_wr", 32'(o_writeAdd), 32'(exp_wr));
            chk("proc_flags", 32'({o_SOP_fromFSM, o_valid_toCONV, o_EoP}), 32'b110);
        end
        step();
        chk("proc_end_flags", 32'({o_SOP_fromFSM, o_valid_toCONV, o_EoP}), 32'b001);
        i_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("done_hold", 32'({o_SOP_fromFSM, o_EoP}), 32'b01);
        end

        // Read-out of the processed frame.
        i_SoP = 1'b0;
        step();
        chk("done_exit_eop", 32'(o_EoP), 1);
        step();
        chk("read_start_rd", 32'(o_readAdd), 0);
        chk("read_start_eop", 32'(o_EoP), 1);
        for (int e = 1; e <= h; e++) begin
            i_valid = 1'b1;
            step();
            chk("read_rd", 32'(o_readAdd), 32'(e));
            chk("read_wr", 32'(o_writeAdd), 32'(e));
            i_valid = 1'b0;
            if (e < h) begin
                step();
                chk("read_hold", 32'(o_readAdd), 32'(e));
            end
        end
        step();
        chk("read_cb", 32'(o_changeBlock), 1);
        chk("read_eop_clr", 32'(o_EoP), 0);
        chk("read_bank_kept", 32'(o_bankSel), 32'b0010);
        step();
        chk("read_cb_pulse", 32'(o_changeBlock), 0);

        // Reset in the middle of a process pass.
        i_imgLength = 10'($urandom_range(12, 40));
        i_valid = 1'b1;
        i_SoP = 1'b1;
        step();
        for (int c = 0; c < 10; c++) step();
        chk("mid_rd", 32'(o_readAdd), 10);
        chk("mid_bank", 32'(o_bankSel), 32'b0010);
        i_reset = 1'b1; i_SoP = 1'b0; i_valid = 1'b0;
        step();
        chk_reset_values("mid_reset");
        i_reset = 1'b0;
        step();

`ifdef CONV_FSM_STALL_EN
        // Starved host: both addresses hold and the convolver sees no valid.
        i_imgLength = 10'd20;
        i_valid = 1'b1;
        i_SoP = 1'b1;
        step();
        for (int c = 0; c < 8; c++) step();
        chk("stall_pre_rd", 32'(o_readAdd), 8);
        chk("stall_pre_wr", 32'(o_writeAdd), 2);
        i_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("stall_rd", 32'(o_readAdd), 8);
            chk("stall_wr", 32'(o_writeAdd), 2);
            chk("stall_valid", 32'(o_valid_toCONV), 0);
        end
        i_valid = 1'b1;
        step();
        chk("stall_resume_rd", 32'(o_readAdd), 9);
        i_reset = 1'b1; i_SoP = 1'b0; i_valid = 1'b0;
        step();
        i_reset = 1'b0;
        step();
`endif

        // Illegal commands.
        i_load = 1'b1; i_SoP = 1'b1;
        step();
        chk("err_both_pe", 32'(o_protoErr), 1);
        chk("err_both_idle", 32'({o_SOP_fromFSM, o_EoP}), 0);
        i_load = 1'b0; i_SoP = 1'b0;
        step();
        chk("err_both_pulse", 32'(o_protoErr), 0);
        i_imgLength = 10'd2;
        i_SoP = 1'b1;
        step();
        chk("err_short_pe", 32'(o_protoErr), 1);
        chk("err_short_eop", 32'(o_EoP), 1);
        chk("err_short_valid", 32'(o_valid_toCONV), 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("err_short_hold", 32'({o_protoErr, o_valid_toCONV, o_SOP_fromFSM, o_EoP}), 32'b0001);
        end
        i_SoP = 1'b0;
        i_reset = 1'b1;
        step();
        chk_reset_values("final_reset");
        i_reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
